// File: rtl/audioqsys_dac_i2s_tx.sv
//------------------------------------------------------------------------------
// Module  : audioqsys_dac_i2s_tx
// Brief   : Avalon-MM stereo sample FIFO serialised onto the codec DACDAT line
//           in I2S format; the codec masters BCLK and DACLRCK.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module audioqsys_dac_i2s_tx #(
  parameter int DATA_WIDTH = 16,
  parameter int FIFO_DEPTH = 16
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [1:0]  address,
  input  logic        chipselect,
  input  logic        write_n,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  input  logic        bclk,
  input  logic        daclrck,
  output logic        dacdat
);

  localparam int c_PTR_W = $clog2(FIFO_DEPTH);
  localparam int c_CNT_W = c_PTR_W + 1;
  localparam int c_BIT_W = $clog2(DATA_WIDTH) + 1;

  logic [2:0]              r_bclk_sync;
  logic [2:0]              r_lrck_sync;
  logic [2*DATA_WIDTH-1:0] r_mem [FIFO_DEPTH];
  logic [c_PTR_W-1:0]      r_wr_ptr;
  logic [c_PTR_W-1:0]      r_rd_ptr;
  logic [c_CNT_W-1:0]      r_count;
  logic [DATA_WIDTH-1:0]   r_left;
  logic [DATA_WIDTH-1:0]   r_right_hold;
  logic [DATA_WIDTH-1:0]   r_shift;
  logic [c_BIT_W-1:0]      r_bit_cnt;
  logic                    r_enable;
  logic                    r_underflow;
  logic                    r_overflow;
  logic                    r_dacdat;
  logic [31:0]             r_readdata;

  logic w_bclk_fall, w_lrck_fall, w_lrck_rise;
  logic w_write, w_push, w_ctrl_wr, w_flush, w_clear;
  logic w_full, w_empty, w_pop, w_push_ok;
  logic [7:0] w_count8;
  logic w_unused;

  // Bit [2] of each chain is the edge-detect stage behind the 2-flop synchroniser
  assign w_bclk_fall = r_bclk_sync[2] & ~r_bclk_sync[1];
  assign w_lrck_fall = r_lrck_sync[2] & ~r_lrck_sync[1];
  assign w_lrck_rise = ~r_lrck_sync[2] & r_lrck_sync[1];

  assign w_write   = chipselect & ~write_n;
  assign w_push    = w_write & (address == 2'd1);
  assign w_ctrl_wr = w_write & (address == 2'd3);
  assign w_flush   = w_ctrl_wr & writedata[2];
  assign w_clear   = w_ctrl_wr & writedata[1];
  assign w_full    = (r_count == c_CNT_W'(FIFO_DEPTH));
  assign w_empty   = (r_count == '0);
  assign w_pop     = w_lrck_fall & r_enable & ~w_empty;
  assign w_push_ok = w_push & ~w_full;
  assign w_count8  = 8'(r_count);
  assign w_unused  = ^writedata;

  assign readdata = r_readdata;
  assign dacdat   = r_dacdat;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_bclk_sync <= '0;
      r_lrck_sync <= '0;
    end else begin
      r_bclk_sync <= {r_bclk_sync[1:0], bclk};
      r_lrck_sync <= {r_lrck_sync[1:0], daclrck};
    end
  end

  always_ff @(posedge clk) begin
    if (w_push_ok) begin
      r_mem[r_wr_ptr] <= {r_left, writedata[DATA_WIDTH-1:0]};
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (w_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push_ok) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)     r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push_ok, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_left      <= '0;
      r_enable    <= 1'b0;
      r_underflow <= 1'b0;
      r_overflow  <= 1'b0;
    end else begin
      if (w_write && address == 2'd0) r_left <= writedata[DATA_WIDTH-1:0];
      if (w_ctrl_wr) r_enable <= writedata[0];
      // A new event in the same cycle as a clear keeps the flag set
      if (w_push && w_full)                    r_overflow <= 1'b1;
      else if (w_clear)                        r_overflow <= 1'b0;
      if (w_lrck_fall && r_enable && w_empty)  r_underflow <= 1'b1;
      else if (w_clear)                        r_underflow <= 1'b0;
    end
  end

  // LRCK edges take priority over a coincident BCLK fall
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_shift      <= '0;
      r_right_hold <= '0;
      r_bit_cnt    <= '0;
      r_dacdat     <= 1'b0;
    end else if (w_lrck_fall) begin
      r_bit_cnt <= '0;
      if (w_pop) begin
        r_shift      <= r_mem[r_rd_ptr][2*DATA_WIDTH-1:DATA_WIDTH];
        r_right_hold <= r_mem[r_rd_ptr][DATA_WIDTH-1:0];
      end else begin
        r_shift      <= '0;
        r_right_hold <= '0;
      end
    end else if (w_lrck_rise) begin
      r_bit_cnt <= '0;
      r_shift   <= r_right_hold;
    end else if (w_bclk_fall) begin
      if (r_bit_cnt < c_BIT_W'(DATA_WIDTH)) begin
        r_dacdat  <= r_shift[DATA_WIDTH-1];
        r_shift   <= {r_shift[DATA_WIDTH-2:0], 1'b0};
        r_bit_cnt <= r_bit_cnt + 1'b1;
      end else begin
        r_dacdat <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_readdata <= '0;
    end else begin
      case (address)
        2'd2:    r_readdata <= {14'b0, w_empty, w_full, w_count8, 6'b0, r_overflow, r_underflow};
        2'd3:    r_readdata <= {31'b0, r_enable};
        default: r_readdata <= '0;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_audioqsys_dac_i2s_tx.sv
//------------------------------------------------------------------------------
// Module  : tb_audioqsys_dac_i2s_tx
// Brief   : Self-checking bench with a queue-based model of the sample FIFO.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module tb_audioqsys_dac_i2s_tx;

  localparam int DW    = 16;
  localparam int DEPTH = 16;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [1:0]  address = '0;
  logic        chipselect = 1'b0;
  logic        write_n = 1'b1;
  logic [31:0] writedata = '0;
  logic [31:0] readdata;
  logic        bclk = 1'b1;
  logic        daclrck = 1'b1;
  logic        dacdat;

  audioqsys_dac_i2s_tx #(.DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .readdata(readdata),
    .bclk(bclk), .daclrck(daclrck), .dacdat(dacdat)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [2*DW-1:0] q[$];
  bit              m_en, m_unf, m_ovf;
  logic [DW-1:0]   m_left;

  logic          exp_bit = 1'b0;
  bit            check_en = 1'b0;
  int            bit_idx = 0;
  logic [DW-1:0] cap_sr = '0;
  logic [DW-1:0] last_left, last_right;

  // The codec samples DACDAT on BCLK rising edges
  always @(posedge bclk) begin
    if (check_en) begin
      checks++;
      if (dacdat !== exp_bit) begin
        errors++;
        $display("FAIL dacdat bit %0d at %0t: got %b, want %b", bit_idx, $time, dacdat, exp_bit);
      end
      cap_sr = {cap_sr[DW-2:0], dacdat};
      bit_idx++;
    end
  end

  task automatic check32(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %h, want %h", name, got, want);
    end
  endtask

  function automatic logic [31:0] exp_status();
    int n = q.size();
    return {14'b0, n == 0, n == DEPTH, 8'(n), 6'b0, m_ovf, m_unf};
  endfunction

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    @(negedge clk);
    address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
    @(negedge clk);
    chipselect = 1'b0; write_n = 1'b1;
    case (a)
      2'd0: m_left = d[DW-1:0];
      2'd1: if (q.size() == DEPTH) m_ovf = 1'b1; else q.push_back({m_left, d[DW-1:0]});
      2'd3: begin
        m_en = d[0];
        if (d[1]) begin m_ovf = 1'b0; m_unf = 1'b0; end
        if (d[2]) q.delete();
      end
      default: ;
    endcase
  endtask

  task automatic rd(input logic [1:0] a, output logic [31:0] d);
    @(negedge clk);
    address = a; chipselect = 1'b1; write_n = 1'b1;
    @(posedge clk);
    #1 d = readdata;
    chipselect = 1'b0;
  endtask

  task automatic check_regs(input string name);
    logic [31:0] v;
    rd(2'd2, v);
    check32({name, "_status"}, v, exp_status());
    rd(2'd3, v);
    check32({name, "_ctrl"}, v, {31'b0, m_en});
  endtask

  task automatic run_slot(input logic [DW-1:0] word, input logic lr, input int nbits,
                          output logic [DW-1:0] cap);
    @(negedge clk);
    daclrck = lr;
    cap_sr  = '0;
    for (int i = 0; i < nbits; i++) begin
      #80 bclk = 1'b0;
      exp_bit  = word[DW-1-i];
      check_en = 1'b1;
      #80 bclk = 1'b1;
    end
    #1 cap = cap_sr;
  endtask

  task automatic model_pop(output logic [2*DW-1:0] p);
    p = '0;
    if (m_en && q.size() > 0) p = q.pop_front();
    else if (m_en) m_unf = 1'b1;
  endtask

  task automatic run_frame();
    logic [2*DW-1:0] p;
    model_pop(p);
    run_slot(p[2*DW-1:DW], 1'b0, DW, last_left);
    run_slot(p[DW-1:0], 1'b1, DW, last_right);
    check_en = 1'b0;
  endtask

  task automatic push_pair(input logic [DW-1:0] l, input logic [DW-1:0] r);
    wr(2'd0, 32'(l));
    wr(2'd1, 32'(r));
  endtask

  initial begin
    logic [31:0]     v;
    logic [DW-1:0]   l, r, dummy;
    logic [2*DW-1:0] p;

    // Reset state
    repeat (3) @(negedge clk);
    check32("reset_readdata", readdata, 32'h0);
    check32("reset_dacdat", 32'(dacdat), 32'h0);
    reset_n = 1'b1;
    rd(2'd2, v); check32("reset_status", v, 32'h0002_0000);
    rd(2'd3, v); check32("reset_ctrl", v, 32'h0);
    run_frame();
    check_regs("idle_frame");

    // Single known pair
    wr(2'd0, 32'h0000_A5A5);
    wr(2'd1, 32'h0000_0F0F);
    rd(2'd2, v); check32("one_pair_status", v, 32'h0000_0100);
    wr(2'd3, 32'h1);
    run_frame();
    check32("left_word", 32'(last_left), 32'h0000_A5A5);
    check32("right_word", 32'(last_right), 32'h0000_0F0F);
    rd(2'd2, v); check32("drained_status", v, 32'h0002_0000);

    // Overflow with enable off
    wr(2'd3, 32'h0);
    for (int i = 0; i < DEPTH + 1; i++) push_pair(DW'($urandom), DW'($urandom));
    rd(2'd2, v); check32("full_status", v, 32'h0001_1002);
    check_regs("full_model");
    wr(2'd3, 32'h2);
    rd(2'd2, v); check32("ovf_cleared", v, 32'h0001_1000);
    wr(2'd3, 32'h4);
    check_regs("flushed");

    // Underflow on an empty FIFO, then a pair still transmits
    wr(2'd3, 32'h1);
    run_frame();
    run_frame();
    rd(2'd2, v); check32("underflow_status", v, 32'h0002_0001);
    l = DW'($urandom); r = DW'($urandom);
    push_pair(l, r);
    run_frame();
    check32("after_unf_left", 32'(last_left), 32'(l));
    check32("after_unf_right", 32'(last_right), 32'(r));
    rd(2'd2, v); check32("unf_sticky", v, 32'h0002_0001);
    wr(2'd3, 32'h3);
    check_regs("unf_cleared");

    // Flush + enable, next frame is silent
    for (int i = 0; i < 4; i++) push_pair(DW'($urandom), DW'($urandom));
    wr(2'd3, 32'h5);
    rd(2'd2, v); check32("flush_en_status", v, 32'h0002_0000);
    run_frame();
    check32("flush_frame_left", 32'(last_left), 32'h0);
    rd(2'd2, v); check32("flush_unf_status", v, 32'h0002_0001);

    // Randomised traffic against the model
    for (int it = 0; it < 30; it++) begin
      case ($urandom_range(0, 3))
        0: for (int k = $urandom_range(1, 6); k > 0; k--) push_pair(DW'($urandom), DW'($urandom));
        1: run_frame();
        2: wr(2'd3, {29'b0, ($urandom_range(0, 3) == 0), 1'($urandom), 1'($urandom)});
        default: begin run_frame(); run_frame(); end
      endcase
      check_regs("random");
    end
    wr(2'd3, 32'h1);
    for (int i = 0; i < DEPTH; i++) if (q.size() > 0) run_frame();
    check_regs("drain");

    // Reset in the middle of a left slot
    wr(2'd3, 32'h3);
    push_pair('1, '1);
    model_pop(p);
    run_slot(p[2*DW-1:DW], 1'b0, 5, dummy);
    check_en = 1'b0;
    #20 reset_n = 1'b0;
    #1;
    check32("midrst_dacdat", 32'(dacdat), 32'h0);
    check32("midrst_readdata", readdata, 32'h0);
    q.delete(); m_en = 1'b0; m_unf = 1'b0; m_ovf = 1'b0; m_left = '0;
    daclrck = 1'b1;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    rd(2'd2, v); check32("post_rst_status", v, 32'h0002_0000);
    run_frame();
    check32("post_rst_left", 32'(last_left), 32'h0);
    check_regs("post_rst");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #5ms;
    errors++;
    $display("FAIL timeout: got no finish, want finish before 5ms");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
